// File: rtl/div_ctrl_if.sv
// Controller <-> iterative divider bundle.
interface div_ctrl_if;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  modport master (
    output div_start_o,
    output div_annul_o,
    output div_signed_o,
    output div_opdata1_o,
    output div_opdata2_o,
    input  div_result_i,
    input  div_ready_i
  );

  modport slave (
    input  div_start_o,
    input  div_annul_o,
    input  div_signed_o,
    input  div_opdata1_o,
    input  div_opdata2_o,
    output div_result_i,
    output div_ready_i
  );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: issues DIV/DIVU to the divider, stalls, writes HI/LO.
// Optional DIV_ZERO_TRAP_EN traps zero divisors instead of issuing them.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  div_ctrl_if.master  dbus,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_we_o,
  output logic        div_zero_exc_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic go;
  logic zero_hit;
  logic stall;
  logic start;
  logic annul;
  logic we;

  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        sgn_q;

`ifdef DIV_ZERO_TRAP_EN
  assign zero_hit = (opdata2_i == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  assign go = (state_q == IDLE) && div_req_i && !flush_i;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
    annul   = 1'b0;
    we      = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        if (go && !zero_hit) begin
          state_d = BUSY;
          stall   = 1'b1;
        end
      end
      state_q == BUSY: begin
        start = 1'b1;
        if (flush_i) begin
          annul   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (dbus.div_ready_i) state_d = DONE;
        end
      end
      state_q == DONE: begin
        we      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      state_q <= state_d;
      if (go && !zero_hit) begin
        op1_q <= opdata1_i;
        op2_q <= opdata2_i;
        sgn_q <= div_signed_i;
      end
      if (state_q == BUSY && !flush_i && dbus.div_ready_i) begin
        hi_o <= dbus.div_result_i[63:32];
        lo_o <= dbus.div_result_i[31:0];
      end
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic exc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_q <= 1'b0;
    else      exc_q <= go && zero_hit;
  end

  assign div_zero_exc_o = exc_q;
`else
  assign div_zero_exc_o = 1'b0;
`endif

  // IDLE stall is combinational on the request; hold it low while in reset
  assign stallreq_o         = stall & rst;
  assign hilo_we_o          = we;
  assign dbus.div_start_o   = start;
  assign dbus.div_annul_o   = annul;
  assign dbus.div_signed_o  = sgn_q;
  assign dbus.div_opdata1_o = op1_q;
  assign dbus.div_opdata2_o = op2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized scoreboard bench for div_ctrl with a behavioural divider model.
// Expected HI/LO come from plain arithmetic on the issued operands.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sgn;
  logic        flush;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        we;
  logic        exc;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt;

  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div_ctrl_if dbus ();

  div_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .div_req_i      (req),
    .div_signed_i   (sgn),
    .opdata1_i      (op1),
    .opdata2_i      (op2),
    .flush_i        (flush),
    .dbus           (dbus.master),
    .stallreq_o     (stall),
    .hi_o           (hi),
    .lo_o           (lo),
    .hilo_we_o      (we),
    .div_zero_exc_o (exc)
  );

  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sg);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // divider: result becomes valid lat edges after start rises
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt               <= 0;
      dbus.div_ready_i  <= 1'b0;
      dbus.div_result_i <= '0;
    end else if (!dbus.div_start_o) begin
      cnt              <= 0;
      dbus.div_ready_i <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (cnt + 1 >= lat) begin
        dbus.div_ready_i  <= 1'b1;
        dbus.div_result_i <= ref_div(dbus.div_opdata1_o,
                                     dbus.div_opdata2_o,
                                     dbus.div_signed_o);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: every HI/LO write must match the oldest outstanding op
  always @(negedge clk) begin
    if (rst && we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hilo_unexpected act=1 exp=0 t=%0t", $time);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // mode 0: complete, 1: flush on BUSY cycle 'at', 2: reset on BUSY cycle 'at'
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input int l,
                        input int mode, input int at);
    int n;
    chk("idle_start", {63'd0, dbus.div_start_o}, 64'd0);
    lat   = l;
    req   = 1'b1;
    op1   = a;
    op2   = b;
    sgn   = sg;
    flush = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    if (b == 32'd0) begin
      #1 chk("zero_stall", {63'd0, stall}, 64'd0);
      @(posedge clk);
      #1 chk("zero_exc", {63'd0, exc}, 64'd1);
      chk("zero_start", {63'd0, dbus.div_start_o}, 64'd0);
      req = 1'b0;
      @(posedge clk);
      #1 chk("zero_exc_off", {63'd0, exc}, 64'd0);
      chk("zero_start2", {63'd0, dbus.div_start_o}, 64'd0);
      return;
    end
`endif
    #1 chk("req_stall", {63'd0, stall}, 64'd1);
    if (mode == 0) sb.push_back(ref_div(a, b, sg));
    @(posedge clk);
    #1;
    chk("start", {63'd0, dbus.div_start_o}, 64'd1);
    chk("latch_ops", {dbus.div_opdata1_o, dbus.div_opdata2_o}, {a, b});
    chk("latch_sgn", {63'd0, dbus.div_signed_o}, {63'd0, sg});
    n = 1;
    while (n < 200) begin
      if (dbus.div_start_o) begin
        if (mode == 1 && n == at) begin
          flush = 1'b1;
          #1 chk("annul", {63'd0, dbus.div_annul_o}, 64'd1);
          chk("flush_stall", {63'd0, stall}, 64'd0);
          @(posedge clk);
          #1;
          flush = 1'b0;
          req   = 1'b0;
          chk("flush_idle", {61'd0, dbus.div_start_o,
                             dbus.div_annul_o, we}, 64'd0);
          @(posedge clk);
          #1 chk("flush_stay", {63'd0, dbus.div_start_o}, 64'd0);
          return;
        end
        if (mode == 2 && n == at) begin
          rst = 1'b0;
          #1;
          chk("rst_ctl", {59'd0, dbus.div_start_o, dbus.div_annul_o,
                          stall, we, exc}, 64'd0);
          chk("rst_hilo", {hi, lo}, 64'd0);
          chk("rst_ops", {dbus.div_opdata1_o, dbus.div_opdata2_o}, 64'd0);
          chk("rst_sgn", {63'd0, dbus.div_signed_o}, 64'd0);
          @(posedge clk);
          #1;
          req = 1'b0;
          rst = 1'b1;
          return;
        end
        chk("busy_stall", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1;
        n++;
      end else if (we) begin
        chk("done_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("after_done", {63'd0, dbus.div_start_o}, 64'd0);
        return;
      end else begin
        checks++;
        errors++;
        $display("FAIL lost_op act=idle exp=busy_or_done t=%0t", $time);
        req = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout act=%0d exp=done t=%0t", n, $time);
    req = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    req   = 1'b0;
    sgn   = 1'b0;
    flush = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {59'd0, dbus.div_start_o, dbus.div_annul_o,
                      stall, we, exc}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b0, 4, 0, 0);
    chk("u100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 3, 0, 0);
    chk("s_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd1000, 32'd3, 1'b0, 15, 1, 10);
    run_op(32'd77, 32'd5, 1'b0, 2, 1, 3);
    run_op(32'd50, 32'd5, 1'b0, 5, 0, 0);
    chk("b2b_1", {hi, lo}, {32'd0, 32'd10});
    run_op(32'd9, 32'd4, 1'b0, 5, 0, 0);
    chk("b2b_2", {hi, lo}, {32'd1, 32'd2});
    run_op(32'd1234, 32'd0, 1'b0, 3, 0, 0);
`ifndef DIV_ZERO_TRAP_EN
    chk("zero_div", {hi, lo}, 64'd0);
`endif
    run_op(32'd55, 32'd6, 1'b1, 8, 2, 4);
    run_op(32'd123, 32'd10, 1'b0, 3, 0, 0);
    chk("post_rst", {hi, lo}, {32'd3, 32'd12});

    req   = 1'b1;
    flush = 1'b1;
    op2   = 32'd3;
    #1 chk("idle_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1 chk("idle_flush_start", {63'd0, dbus.div_start_o}, 64'd0);
    req   = 1'b0;
    flush = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int          l;
      int          m;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      l = $urandom_range(1, 12);
      m = ($urandom_range(0, 5) == 0) ? 1 : 0;
      run_op(a, b, 1'($urandom_range(0, 1)), l, m, $urandom_range(1, l + 1));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst (rst low = reset).
REQ-002 clk  input  1  rising-edge clock shared with the divider.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 div_req_i  input  1  EX stage holds a DIV/DIVU instruction.
REQ-005 div_signed_i  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 opdata1_i, opdata2_i  input  32 each  dividend and divisor from EX.
REQ-007 flush_i  input  1  pipeline flush (exception or branch annul).
REQ-008 div_result_i  input  64  divider result: {remainder, quotient}.
REQ-009 div_ready_i  input  1  divider result valid.
REQ-010 div_start_o, div_annul_o, div_signed_o  output  1 each  drive the divider start, annul and signed inputs.
REQ-011 div_opdata1_o, div_opdata2_o  output  32 each  latched operands sent to the divider.
REQ-012 stallreq_o  output  1  stall request to the pipeline controller.
REQ-013 hi_o, lo_o  output  32 each  remainder and quotient for the HI/LO file.
REQ-014 hilo_we_o  output  1  one-cycle HI/LO write enable.
REQ-015 div_zero_exc_o  output  1  divide-by-zero exception pulse (see Configuration).

Function
REQ-016 Registered FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE -> BUSY when div_req_i=1 and flush_i=0.
 - At that edge, latch opdata1_i, opdata2_i and div_signed_i into div_opdata*_o and div_signed_o.
REQ-018 div_start_o SHALL be 1 in BUSY and 0 in all other states; operands stay stable while it is 1.
REQ-019 BUSY + flush_i=1 -> IDLE; div_annul_o SHALL be 1 for exactly that cycle, and HI/LO SHALL NOT be written.
REQ-020 Flush has priority: in BUSY, flush_i=1 with div_ready_i=1 SHALL take the annul path.
REQ-021 BUSY + div_ready_i=1 + flush_i=0 -> DONE; at that edge hi_o <= div_result_i[63:32] and lo_o <= div_result_i[31:0].
REQ-022 In DONE, hilo_we_o SHALL be 1 for exactly one cycle; DONE -> IDLE unconditionally after one cycle.
 - div_start_o low in DONE lets the divider drop div_ready_i and return free.
REQ-023 stallreq_o is combinational: 1 when (IDLE and div_req_i and !flush_i), or when in BUSY and not flushed; 0 in DONE.
REQ-024 In DONE, div_req_i SHALL be ignored, because it is still the retiring instruction.
REQ-025 A new div_req_i in the cycle after DONE SHALL start a fresh operation (back-to-back support).
REQ-026 Minimum stall: request cycle + BUSY cycles up to and including the div_ready_i cycle.
 - The instruction retires in the DONE cycle.
REQ-027 flush_i in IDLE SHALL suppress a same-cycle request: no latch, no stall.

Reset
REQ-028 While rst=0, asynchronously force:
 - state = IDLE;
 - all outputs = 0, including hi_o, lo_o and the latched operands.
REQ-029 Reset asserted mid-BUSY SHALL drop div_start_o immediately without pulsing div_annul_o.
 - The divider is reset by the same rst.

Configuration
REQ-030 Macro DIV_ZERO_TRAP_EN.
 - Defined: IDLE request with opdata2_i=0 and flush_i=0 SHALL NOT enter BUSY. Instead:
   - div_zero_exc_o = 1 for one cycle, registered on the following edge;
   - stallreq_o = 0;
   - no HI/LO write.
 - Undefined: div_zero_exc_o is tied 0, and zero divisors are issued normally (divider returns 0 result).

Verification
REQ-031 Unsigned 100/7, no flush -> single hilo_we_o pulse with lo_o=14, hi_o=2; stallreq_o low in the DONE cycle.
REQ-032 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-033 flush_i asserted on the 10th BUSY cycle -> div_annul_o one-cycle pulse, start drops, no hilo_we_o, state IDLE.
REQ-034 Two back-to-back requests, 50/5 then 9/4 -> two hilo_we_o pulses (lo=10,hi=0 then lo=2,hi=1), second start at least one cycle after the first DONE.
REQ-035 opdata2_i=0 with DIV_ZERO_TRAP_EN -> div_zero_exc_o pulse, div_start_o never 1; without the macro -> lo_o=0, hi_o=0 written.
REQ-036 rst pulled low mid-BUSY -> all outputs 0 immediately; the next request after release completes correctly.
